// File: rtl/online_product_converter.sv
// Converts an MSD-first radix-2 signed-digit stream into a two's-complement fraction, on the fly.
// Latency: result/out_valid registered one cycle after the final digit is sampled.
// Backpressure: none; one digit per cycle is accepted whenever a frame is open.
module online_product_converter #(
    parameter int DIGITS = 64,
    parameter int SKIP   = 0,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [1:0]        p_value,
    output logic [DIGITS:0]   result,
    output logic              out_valid,
    output logic              busy,
    output logic              err
);

    localparam int W = DIGITS + 1;

    logic [W-1:0]     q, qm;
    logic [W-1:0]     q_base, qm_base, q_next, qm_next;
    logic [CNT_W-1:0] cnt, cnt_base, cnt_inc, cnt_next;
    logic             err_base, err_next, busy_base;
    logic             accept, skip_phase, done;

    // A start pulse re-initialises the frame before the same-cycle digit is applied.
    always_comb begin
        q_base     = start ? '0 : q;
        qm_base    = start ? '1 : qm;
        cnt_base   = start ? '0 : cnt;
        err_base   = start ? 1'b0 : err;
        busy_base  = start | busy;
        accept     = in_valid & busy_base;
        skip_phase = int'(cnt_base) < SKIP;
        cnt_inc    = cnt_base + CNT_W'(1);
        cnt_next   = accept ? cnt_inc : cnt_base;
        done       = accept && (int'(cnt_inc) == SKIP + DIGITS);
        q_next     = q_base;
        qm_next    = qm_base;
        err_next   = err_base;
        if (accept) begin
            if (p_value == 2'b11)
                err_next = 1'b1;
            // Q and QM = Q-1 are both kept so each digit is a pure select-and-shift.
            if (!skip_phase) begin
                case (p_value)
                    2'b10: begin
                        q_next  = {q_base[W-2:0], 1'b1};
                        qm_next = {q_base[W-2:0], 1'b0};
                    end
                    2'b01: begin
                        q_next  = {qm_base[W-2:0], 1'b1};
                        qm_next = {qm_base[W-2:0], 1'b0};
                    end
                    default: begin
                        q_next  = {q_base[W-2:0], 1'b0};
                        qm_next = {qm_base[W-2:0], 1'b1};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            q         <= '0;
            qm        <= '1;
            cnt       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            q         <= q_next;
            qm        <= qm_next;
            cnt       <= cnt_next;
            err       <= err_next;
            busy      <= busy_base & ~done;
            out_valid <= done;
            if (done)
                result <= q_next;
        end
    end

endmodule

// File: tb/tb_online_product_converter.sv
// Drives two converter instances (SKIP=0 and SKIP=2, DIGITS=4) with shared stimulus and
// compares every cycle against an arithmetic frame model.
module tb_online_product_converter;

    localparam logic [1:0] P = 2'b10;
    localparam logic [1:0] N = 2'b01;
    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       asyn_reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] p_value = 2'b00;

    logic [4:0] res0, res1;
    logic       ov0, ov1, busy0, busy1, err0, err1;

    int n_chk = 0;
    int n_fail = 0;

    // model state: index 0 = SKIP 0, index 1 = SKIP 2
    int         skip_of [2] = '{0, 2};
    int         m_cnt   [2];
    int         m_val   [2];
    bit         m_busy  [2];
    bit         m_err   [2];
    bit         m_ov    [2];
    logic [4:0] m_res   [2];

    always #5 clk = ~clk;

    online_product_converter #(.DIGITS(4), .SKIP(0), .CNT_W(4)) u0 (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .in_valid(in_valid),
        .p_value(p_value), .result(res0), .out_valid(ov0), .busy(busy0), .err(err0)
    );

    online_product_converter #(.DIGITS(4), .SKIP(2), .CNT_W(4)) u1 (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .in_valid(in_valid),
        .p_value(p_value), .result(res1), .out_valid(ov1), .busy(busy1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame value as a plain integer: val = sum d_i * 2^(4-i); result is its 5-bit two's complement.
    task automatic model_step(input logic r, input logic s, input logic v, input logic [1:0] p);
        int d;
        logic [31:0] tmp;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_cnt[k] = 0; m_val[k] = 0; m_busy[k] = 0; m_err[k] = 0;
                m_ov[k] = 0; m_res[k] = '0;
            end else begin
                m_ov[k] = 0;
                if (s) begin
                    m_cnt[k] = 0; m_val[k] = 0; m_err[k] = 0; m_busy[k] = 1;
                end
                if (v && m_busy[k]) begin
                    d = (p == P) ? 1 : (p == N) ? -1 : 0;
                    if (p == X) m_err[k] = 1;
                    if (m_cnt[k] >= skip_of[k]) m_val[k] = m_val[k] * 2 + d;
                    m_cnt[k]++;
                    if (m_cnt[k] == skip_of[k] + 4) begin
                        tmp = m_val[k];
                        m_res[k] = tmp[4:0];
                        m_ov[k] = 1;
                        m_busy[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic v, input logic [1:0] p);
        asyn_reset = r; start = s; in_valid = v; p_value = p;
        @(posedge clk);
        #1;
        model_step(r, s, v, p);
        chk("res0",  res0,  m_res[0]);
        chk("ov0",   ov0,   m_ov[0]);
        chk("busy0", busy0, m_busy[0]);
        chk("err0",  err0,  m_err[0]);
        chk("res1",  res1,  m_res[1]);
        chk("ov1",   ov1,   m_ov[1]);
        chk("busy1", busy1, m_busy[1]);
        chk("err1",  err1,  m_err[1]);
    endtask

    initial begin
        // reset
        cycle(1, 0, 0, Z);
        cycle(1, 0, 0, Z);
        chk("rst_q",  u0.q,  5'b00000);
        chk("rst_qm", u0.qm, 5'b11111);
        cycle(0, 0, 1, P);
        chk("idle_ignored_busy", busy0, 1'b0);

        // +1,0,-1,+1 back-to-back
        cycle(0, 1, 1, P);
        chk("busy_rise", busy0, 1'b1);
        cycle(0, 0, 1, Z);
        cycle(0, 0, 1, N);
        cycle(0, 0, 1, P);
        chk("t1_res", res0, 5'b00111);
        chk("t1_ov",  ov0,  1'b1);
        chk("t1_busy", busy0, 1'b0);
        cycle(0, 0, 0, Z);
        chk("t1_ov_pulse", ov0, 1'b0);

        // all -1, then all 0
        cycle(0, 1, 1, N);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, N);
        chk("t2_neg", res0, 5'b10001);
        cycle(0, 1, 1, Z);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, Z);
        chk("t2_zero", res0, 5'b00000);

        // SKIP=2: two discarded digits, then -1,0,+1,+1
        cycle(0, 1, 1, P);
        cycle(0, 0, 1, P);
        cycle(0, 0, 1, N);
        cycle(0, 0, 1, Z);
        cycle(0, 0, 1, P);
        chk("t3_no_early_ov", ov1, 1'b0);
        cycle(0, 0, 1, P);
        chk("t3_res", res1, 5'b11011);
        chk("t3_ov",  ov1,  1'b1);

        // illegal digit in position 2
        cycle(0, 1, 1, P);
        cycle(0, 0, 1, X);
        chk("t4_err_next", err0, 1'b1);
        cycle(0, 0, 1, P);
        cycle(0, 0, 1, P);
        chk("t4_res", res0, 5'b01011);
        chk("t4_err", err0, 1'b1);
        cycle(0, 1, 0, Z);
        chk("t4_err_clr", err0, 1'b0);

        // abandon after 2 digits, restart with same-cycle digit, gaps mid-frame
        cycle(0, 0, 1, P);
        cycle(0, 0, 1, P);
        cycle(0, 1, 1, P);
        chk("t5_no_ov", ov0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, Z);
        chk("t5_gap_hold", res0, 5'b01011);
        chk("t5_gap_busy", busy0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, Z);
        chk("t5_res", res0, 5'b01000);

        // reset mid-frame
        cycle(0, 1, 1, P);
        cycle(0, 0, 1, N);
        cycle(0, 0, 1, P);
        cycle(1, 0, 1, P);
        chk("t6_res",  res0,  5'b00000);
        chk("t6_busy", busy0, 1'b0);
        chk("t6_qm",   u0.qm, 5'b11111);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, P);
        chk("t6_ignored", res0, 5'b00000);

        // randomized traffic
        cycle(0, 1, 0, Z);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
